// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Stall/flush controller for the pc, IF/ID, ID/EX and EX/MEM
//            registers (load-use, EX redirect, multi-cycle EX) + perf counters.
// Revision : 1.0
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int REDIRECT_BUBBLES = 0,
    parameter int MC_TIMEOUT       = 64,
    parameter int CNT_W            = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_wb_load,
    input  logic [4:0]       ex_wb_rd,
    input  logic             ex_redirect,
    input  logic             ex_mc_start,
    input  logic             ex_mc_done,
    input  logic             perf_clr,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mc_timeout,
    output logic [CNT_W-1:0] cnt_load_use,
    output logic [CNT_W-1:0] cnt_redirect,
    output logic [CNT_W-1:0] cnt_mc_stall
);

    typedef enum logic [1:0] {
        S_INIT       = 2'd0,
        S_RUN        = 2'd1,
        S_REDIR_HOLD = 2'd2,
        S_MC_BUSY    = 2'd3
    } state_t;

    localparam int              C_WD_W     = $clog2(MC_TIMEOUT);
    localparam logic [C_WD_W-1:0] C_WD_MAX = C_WD_W'(MC_TIMEOUT - 1);
    localparam logic [2:0]      C_BUBBLES  = 3'(REDIRECT_BUBBLES);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_bubble;
    logic [C_WD_W-1:0]  r_wd;
    logic [C_WD_W-1:0]  w_wd_inc;
    logic               r_mc_timeout;
    logic [CNT_W-1:0]   r_cnt_lu;
    logic [CNT_W-1:0]   r_cnt_redir;
    logic [CNT_W-1:0]   r_cnt_mc;
    logic               w_load_use;
    logic               w_inc_lu;
    logic               w_inc_redir;
    logic               w_mc_enter;

    assign w_load_use = ex_wb_load && (ex_wb_rd != 5'd0) &&
                        ((id_uses_rs1 && (id_rs1 == ex_wb_rd)) ||
                         (id_uses_rs2 && (id_rs2 == ex_wb_rd)));

    assign w_wd_inc = (r_wd == C_WD_MAX) ? r_wd : r_wd + 1'b1;

    always_comb begin
        w_state_nxt  = r_state;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        w_inc_lu     = 1'b0;
        w_inc_redir  = 1'b0;
        w_mc_enter   = 1'b0;
        case (r_state)
            S_RUN: begin
                if (ex_redirect) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    w_inc_redir = 1'b1;
                    if (REDIRECT_BUBBLES > 0) w_state_nxt = S_REDIR_HOLD;
                end else if (ex_mc_start) begin
                    // A unit finishing in its first cycle never stalls
                    if (!ex_mc_done) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_en     = 1'b0;
                        ex_mem_flush = 1'b1;
                        w_mc_enter   = 1'b1;
                        w_state_nxt  = S_MC_BUSY;
                    end
                end else if (w_load_use) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                    w_inc_lu    = 1'b1;
                end
            end
            S_REDIR_HOLD: begin
                if_id_flush = 1'b1;
                if (r_bubble <= 3'd1) w_state_nxt = S_RUN;
            end
            S_MC_BUSY: begin
                if (ex_mc_done) begin
                    w_state_nxt = S_RUN;
                end else begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_en     = 1'b0;
                    ex_mem_flush = 1'b1;
                end
            end
            default: begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
                w_state_nxt  = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_INIT;
            r_bubble     <= 3'd0;
            r_wd         <= '0;
            r_mc_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_inc_redir)
                r_bubble <= C_BUBBLES;
            else if (r_state == S_REDIR_HOLD)
                r_bubble <= r_bubble - 3'd1;
            if (w_mc_enter)
                r_wd <= '0;
            else if (r_state == S_MC_BUSY)
                r_wd <= w_wd_inc;
            // Sticky: only reset clears the watchdog flag
            if ((r_state == S_MC_BUSY) && (w_wd_inc == C_WD_MAX))
                r_mc_timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_lu    <= '0;
            r_cnt_redir <= '0;
            r_cnt_mc    <= '0;
        end else if (perf_clr) begin
            r_cnt_lu    <= '0;
            r_cnt_redir <= '0;
            r_cnt_mc    <= '0;
        end else begin
            if (w_inc_lu)               r_cnt_lu    <= r_cnt_lu + 1'b1;
            if (w_inc_redir)            r_cnt_redir <= r_cnt_redir + 1'b1;
            if (r_state == S_MC_BUSY)   r_cnt_mc    <= r_cnt_mc + 1'b1;
        end
    end

    assign mc_timeout   = r_mc_timeout;
    assign cnt_load_use = r_cnt_lu;
    assign cnt_redirect = r_cnt_redir;
    assign cnt_mc_stall = r_cnt_mc;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Purpose  : Directed + random bench for pipeline_hazard_ctrl against a
//            cycle-level reference model of the hazard rules.
// Revision : 1.0
// ============================================================================
module tb_pipeline_hazard_ctrl;
    localparam int RB   = 2;
    localparam int MCT  = 8;
    localparam int CW   = 8;
    localparam int MASK = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] id_rs1, id_rs2, ex_wb_rd;
    logic id_uses_rs1, id_uses_rs2, ex_wb_load, ex_redirect, ex_mc_start, ex_mc_done, perf_clr;
    logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_flush, mc_timeout;
    logic [CW-1:0] cnt_load_use, cnt_redirect, cnt_mc_stall;

    pipeline_hazard_ctrl #(.REDIRECT_BUBBLES(RB), .MC_TIMEOUT(MCT), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_wb_load(ex_wb_load), .ex_wb_rd(ex_wb_rd), .ex_redirect(ex_redirect),
        .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done), .perf_clr(perf_clr),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .mc_timeout(mc_timeout), .cnt_load_use(cnt_load_use),
        .cnt_redirect(cnt_redirect), .cnt_mc_stall(cnt_mc_stall)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pending-init flag, remaining hold cycles, busy flag
    bit m_init;
    int m_hold;
    bit m_mc;
    int m_wd;
    bit m_to;
    int m_lu, m_red, m_mcs;

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_flush}
    localparam logic [5:0] C_INIT   = 6'b001011;
    localparam logic [5:0] C_NORMAL = 6'b110100;
    localparam logic [5:0] C_REDIR  = 6'b111110;
    localparam logic [5:0] C_HOLD   = 6'b111100;
    localparam logic [5:0] C_MC     = 6'b000001;
    localparam logic [5:0] C_LU     = 6'b000110;

    function automatic logic [5:0] ctl();
        return {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_flush};
    endfunction

    function automatic bit lu_hit();
        return ex_wb_load && ex_wb_rd != 0 &&
               ((id_uses_rs1 && id_rs1 == ex_wb_rd) || (id_uses_rs2 && id_rs2 == ex_wb_rd));
    endfunction

    function automatic logic [5:0] exp_ctl();
        if (m_init)     return C_INIT;
        if (m_hold > 0) return C_HOLD;
        if (m_mc)       return ex_mc_done ? C_NORMAL : C_MC;
        if (ex_redirect) return C_REDIR;
        if (ex_mc_start) return ex_mc_done ? C_NORMAL : C_MC;
        if (lu_hit())   return C_LU;
        return C_NORMAL;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_init = 1; m_hold = 0; m_mc = 0; m_wd = 0; m_to = 0;
        m_lu = 0; m_red = 0; m_mcs = 0;
    endtask

    task automatic model_update();
        bit lu;
        lu = lu_hit();
        if (m_init) m_init = 0;
        else if (m_hold > 0) m_hold--;
        else if (m_mc) begin
            m_mcs++;
            if (m_wd < MCT - 1) m_wd++;
            if (m_wd >= MCT - 1) m_to = 1;
            if (ex_mc_done) m_mc = 0;
        end else if (ex_redirect) begin
            m_red++;
            m_hold = RB;
        end else if (ex_mc_start) begin
            if (!ex_mc_done) begin m_mc = 1; m_wd = 0; end
        end else if (lu) m_lu++;
        if (perf_clr) begin m_lu = 0; m_red = 0; m_mcs = 0; end
    endtask

    // Called just after a falling edge with inputs already applied
    task automatic step(string tag);
        #1;
        chk({tag, "_ctl"}, 32'(ctl()), 32'(exp_ctl()));
        chk({tag, "_to"}, 32'(mc_timeout), 32'(m_to));
        chk({tag, "_clu"}, 32'(cnt_load_use), m_lu & MASK);
        chk({tag, "_crd"}, 32'(cnt_redirect), m_red & MASK);
        chk({tag, "_cmc"}, 32'(cnt_mc_stall), m_mcs & MASK);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_in(logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2, logic ld,
                          logic [4:0] rd, logic rdr, logic mcs, logic mcd, logic clr);
        id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        ex_wb_load = ld; ex_wb_rd = rd; ex_redirect = rdr;
        ex_mc_start = mcs; ex_mc_done = mcd; perf_clr = clr;
    endtask

    task automatic idle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_ctl", 32'(ctl()), 32'(C_INIT));
        chk("rst_to", 32'(mc_timeout), 32'd0);
        chk("rst_cnt", 32'({cnt_load_use, cnt_redirect, cnt_mc_stall}), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chkc(string tag, logic [5:0] v);
        #1;
        chk(tag, 32'(ctl()), 32'(v));
    endtask

    initial begin
        idle();
        model_reset();
        @(negedge clk);
        do_reset();

        idle(); chkc("init", C_INIT); step("init");
        idle(); chkc("run", C_NORMAL); step("run");

        set_in(5'd1, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        chkc("lu", C_LU); step("lu");
        idle(); chkc("lu_one", C_NORMAL); chk("lu_cnt", 32'(cnt_load_use), 32'd1); step("lu_after");
        set_in(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chkc("lu_x0", C_NORMAL); step("lu_x0");

        idle(); ex_redirect = 1'b1; chkc("redir0", C_REDIR); step("redir0");
        chkc("hold1", C_HOLD); step("hold1");
        idle(); chkc("hold2", C_HOLD); step("hold2");
        chkc("redir3", C_NORMAL); chk("redir_cnt", 32'(cnt_redirect), 32'd1); step("redir3");

        idle(); ex_mc_start = 1'b1; chkc("mc0", C_MC); step("mc0");
        for (int i = 1; i <= 4; i++) begin
            ex_redirect = (i == 2);
            chkc("mc_busy", C_MC); step("mc_busy");
        end
        ex_redirect = 1'b0; ex_mc_done = 1'b1; chkc("mc_done", C_NORMAL); step("mc_done");
        idle(); chk("mc_cnt", 32'(cnt_mc_stall), 32'd5); step("mc_after");

        set_in(5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        chkc("simul", C_REDIR); step("simul");
        idle(); chkc("simul_h1", C_HOLD); step("simul_h1");
        step("simul_h2");
        chk("simul_lu", 32'(cnt_load_use), 32'd1);
        chk("simul_rd", 32'(cnt_redirect), 32'd2);
        step("simul_run");

        idle(); ex_mc_start = 1'b1; step("to_start");
        for (int i = 0; i < 10; i++) begin
            #1 chk("to_flag", 32'(mc_timeout), (i >= 7) ? 32'd1 : 32'd0);
            step("to_busy");
        end
        ex_mc_done = 1'b1; step("to_done");
        idle(); perf_clr = 1'b1; #1 chk("to_keep", 32'(mc_timeout), 32'd1); step("to_clr");
        idle(); #1 chk("clr_cnt", 32'({cnt_load_use, cnt_redirect, cnt_mc_stall}), 32'd0);
        chk("to_after_clr", 32'(mc_timeout), 32'd1);
        step("clr_after");
        do_reset();
        idle(); step("reinit");

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 9) == 0),
                   1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 5) == 0),
                   1'($urandom_range(0, 99) == 0));
            if (m_mc) begin
                ex_mc_start = 1'b1;
                ex_mc_done  = 1'($urandom_range(0, 11) == 0);
            end
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller that drives the enable and flush inputs of every pipeline register: pc, IF/ID, ID/EX, EX/MEM.
- Resolves three hazard classes: load-use, EX redirect (branch mispredict or jump), and multi-cycle EX operations (mul/div).
- Keeps benchmarking counters of lost cycles.
- Sits beside the datapath; its id_ex_flush/id_ex_en outputs feed the ID/EX register directly.

Parameters:
- REDIRECT_BUBBLES, 0, extra cycles IF/ID is held flushed after a redirect (covers imem latency); range 0-7.
- MC_TIMEOUT, 64, max cycles in MC_BUSY before mc_timeout is raised; must be ≥2.
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_rs1  in  5  ID-stage source register 1
- id_rs2  in  5  ID-stage source register 2
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_wb_load  in  1  EX instruction is a load
- ex_wb_rd  in  5  EX destination register
- ex_redirect  in  1  EX resolved a mispredict/jump this cycle
- ex_mc_start  in  1  EX holds a multi-cycle op whose unit is not yet done
- ex_mc_done  in  1  multi-cycle unit result valid
- perf_clr  in  1  synchronous clear of counters
- pc_en  out  1  PC update enable
- if_id_en  out  1  IF/ID enable
- if_id_flush  out  1  IF/ID flush
- id_ex_en  out  1  ID/EX enable
- id_ex_flush  out  1  ID/EX flush (has priority over id_ex_en in the register)
- ex_mem_flush  out  1  insert bubble into EX/MEM
- mc_timeout  out  1  sticky watchdog flag
- cnt_load_use  out  CNT_W  load-use stall cycles
- cnt_redirect  out  CNT_W  redirect events
- cnt_mc_stall  out  CNT_W  cycles spent in MC_BUSY

Behaviour:
- States: INIT, RUN, REDIR_HOLD, MC_BUSY. Reset enters INIT.
- Control outputs are combinational from state and inputs. Counters, mc_timeout, bubble counter and watchdog are registered.
- Reset (rst_n=0) and INIT:
  - pc_en=0, if_id_en=0, id_ex_en=0.
  - if_id_flush=1, id_ex_flush=1, ex_mem_flush=1.
  - Counters=0, mc_timeout=0.
  - First clock edge after deassert: INIT→RUN.
- RUN priority, highest first: redirect > mc_start > load-use > normal.
- Redirect (ex_redirect=1):
  - pc_en=1, if_id_flush=1, id_ex_flush=1, if_id_en=1, id_ex_en=1, ex_mem_flush=0.
  - cnt_redirect+1.
  - If REDIRECT_BUBBLES>0: load bubble counter with REDIRECT_BUBBLES, go REDIR_HOLD. Otherwise stay in RUN.
- Multi-cycle (ex_mc_start=1, ex_redirect=0):
  - pc_en=0, if_id_en=0, id_ex_en=0, ex_mem_flush=1, id_ex_flush=0.
  - Go MC_BUSY; watchdog cleared to 0.
  - If ex_mc_done=1 in the same cycle, no stall: normal outputs, stay in RUN.
- Load-use: ex_wb_load=1, ex_wb_rd≠0, and ((id_uses_rs1 & id_rs1==ex_wb_rd) | (id_uses_rs2 & id_rs2==ex_wb_rd)).
  - pc_en=0, if_id_en=0, id_ex_flush=1, id_ex_en=1.
  - Exactly one cycle: the next cycle EX holds the bubble, so the condition clears.
  - cnt_load_use+1.
- Normal: pc_en=if_id_en=id_ex_en=1, all flushes 0.
- REDIR_HOLD:
  - pc_en=1, if_id_en=1, if_id_flush=1, id_ex_en=1, id_ex_flush=0.
  - Counter decrements each cycle; go RUN when it reaches 1.
  - A new ex_redirect is ignored here (EX holds only bubbles).
- MC_BUSY:
  - Outputs as the multi-cycle stall.
  - cnt_mc_stall+1 per cycle.
  - Watchdog +1 per cycle, saturating. At MC_TIMEOUT-1, mc_timeout←1 (sticky until reset); state still waits for done.
  - ex_mc_done=1: that cycle behaves as normal (all enables 1, ex_mem_flush=0); go RUN.
  - ex_redirect is ignored in MC_BUSY.
- Counters wrap at 2^CNT_W. perf_clr zeroes all counters; it has priority over an increment in the same cycle and does not clear mc_timeout.
- Reset mid-operation: immediate async return to INIT with the outputs above; any in-flight stall is abandoned.

Test Plan:
- Reset release → INIT with all flushes=1 and enables=0 for exactly 1 cycle after rst_n rises, then RUN with pc_en=1, all flushes=0.
- Load x5 in EX (ex_wb_rd=5, ex_wb_load=1), id_rs2=5, id_uses_rs2=1 → one cycle pc_en=0, if_id_en=0, id_ex_flush=1; cnt_load_use=1. Same stimulus with ex_wb_rd=0 → no stall.
- ex_redirect with REDIRECT_BUBBLES=2 → cycle0 both flushes=1; cycles1-2 if_id_flush=1 only; cycle3 normal; cnt_redirect=1.
- ex_mc_start, then ex_mc_done asserted 5 cycles later → pc_en=0 and ex_mem_flush=1 for 5 cycles, release on the done cycle, cnt_mc_stall=5.
- Simultaneous ex_redirect, ex_mc_start and load-use hit → redirect outputs only; no MC_BUSY entry; cnt_load_use unchanged.
- MC_TIMEOUT=8, ex_mc_done withheld 10 cycles → mc_timeout=1 after 7 MC_BUSY cycles and stays 1 after done and after perf_clr; deasserting rst_n clears it.
